mux_sel_sequencer: RTL
======================

// Module: mux_sel_sequencer
// PURPOSE
//   Upstream feeder for the 4x1 word multiplexer. Holds one 32-bit word per
//   source channel (drives A0..A3) and round-robin schedules full slots onto
//   the mux by driving SEL1/SEL2. Presents the selected word to the consumer
//   with a valid/ready handshake and frees the slot on acceptance.
// PARAMETERS
//   DATA_W     32  width of each word / A0..A3
//   START_PTR  0   channel with highest priority after reset (0..3)
// PORTS
//   CLK        in   1       clock, rising edge
//   RST_N      in   1       asynchronous reset, active-low
//   IN_VALID   in   4       per-channel write request, bit i = channel i
//   IN_READY   out  4       per-channel slot empty (accepts write)
//   IN_DATA0   in   DATA_W  channel 0 write word (IN_DATA1..IN_DATA3 same)
//   A0..A3     out  DATA_W  slot registers, wired to mux data inputs
//   SEL1       out  1       select MSB to mux
//   SEL2       out  1       select LSB to mux
//   OUT_VALID  out  1       mux output C holds a valid word
//   OUT_READY  in   1       consumer accepts C this cycle
// BEHAVIOUR
//   - Reset (RST_N low, async): A0..A3=0, full[3:0]=0, IN_READY=4'hF,
//     SEL1=SEL2=0, OUT_VALID=0, ptr=START_PTR, state=IDLE.
//   - Select encoding {SEL1,SEL2}: 00=ch0, 01=ch1, 10=ch2, 11=ch3.
//   - Write: IN_VALID[i]&IN_READY[i] at edge -> Ai<=IN_DATAi, full[i]<=1.
//     IN_READY[i] = ~full[i], purely registered; no same-cycle refill of a
//     slot being drained (refill earliest cycle after acceptance).
//   - Ai holds its value while full and after drain (not cleared).
//   - FSM IDLE: if any full[i], pick first full channel scanning ptr,
//     ptr+1.. mod 4; register SEL to it, OUT_VALID<=1, go PRESENT.
//   - FSM PRESENT: SEL1/SEL2 and selected Ai frozen while OUT_VALID=1.
//     On OUT_VALID&OUT_READY: full[sel]<=0, ptr<=sel+1 mod 4; if another
//     slot full (excluding sel) grant it next cycle back-to-back (stay
//     PRESENT, OUT_VALID stays 1); else OUT_VALID<=0, go IDLE.
//   - Latency: write at edge N into empty block -> OUT_VALID high after
//     edge N+1 (one-cycle arbitration). Back-to-back throughput 1 word/clk.
//   - Writes to non-selected slots during PRESENT are legal; selected slot
//     cannot be written (full).
//   - OUT_READY while OUT_VALID=0 ignored.
//   - Reset mid-transfer: word discarded, all slots empty, no handshake.
// CONFIGURATION
//   MUX_SEQ_STATS_EN defined: extra output DELIV_CNT [31:0], counts
//     accepted words (OUT_VALID&OUT_READY), reset 0, wraps 32'hFFFFFFFF->0.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING
//   1 Reset: RST_N=0 async mid-cycle -> OUT_VALID=0, IN_READY=4'hF, SEL=00.
//   2 Single: write ch2 32'hDEADBEEF, OUT_READY=1 -> OUT_VALID 1 cycle
//     after write, {SEL1,SEL2}=10, A2=DEADBEEF, then IN_READY[2]=1.
//   3 Round-robin: fill all 4 (0x10..0x13), OUT_READY=1 -> grants
//     ch0,1,2,3 on consecutive cycles, OUT_VALID continuous.
//   4 Stall: ch1 full, OUT_READY=0 for 5 cycles, write ch3 meanwhile ->
//     SEL stays 01, A1 stable; after accept next grant is ch3 (11).
//   5 Fairness: ch0 refilled every cycle, ch3 full -> order 0,3,0 (ch0
//     not granted twice in a row while ch3 waits).
//   6 STATS_EN: 7 accepts -> DELIV_CNT=7; preload-wrap check ->
//     0xFFFFFFFF+1 = 0.

Source files
------------

// File: rtl/mux_sel_sequencer_if.sv
// ----------------------------------------------------------------------------
// mux_sel_sequencer_if: slot write, mux drive and consumer handshake bundle. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mux_sel_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] in_data3;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] a2;
  logic [DATA_W-1:0] a3;
  logic              sel1;
  logic              sel2;
  logic              out_valid;
  logic              out_ready;

  // Environment side: producers and the consumer of the mux output.
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, a0, a1, a2, a3, sel1, sel2, out_valid
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, a0, a1, a2, a3, sel1, sel2, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
// ----------------------------------------------------------------------------
// mux_sel_sequencer: 4-slot round-robin feeder for a 4x1 word mux. rev 1.0
// Optional delivered-word counter port under `MUX_SEQ_STATS_EN.
// ----------------------------------------------------------------------------
`default_nettype none

module mux_sel_sequencer #(
  parameter int         DATA_W    = 32,
  parameter logic [1:0] START_PTR = 2'd0
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  mux_sel_sequencer_if.slave   bus
`ifdef MUX_SEQ_STATS_EN
  ,
  output logic [31:0]          deliv_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        full_q, full_d;
  logic [DATA_W-1:0] a_q [4];
  logic [DATA_W-1:0] a_d [4];
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] wdata [4];
  logic [3:0]        wr_en;
  logic [3:0]        other_full;
  logic              accept;

  // First set bit of mask at or after start, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  assign wdata[0] = bus.in_data0;
  assign wdata[1] = bus.in_data1;
  assign wdata[2] = bus.in_data2;
  assign wdata[3] = bus.in_data3;

  assign wr_en      = bus.in_valid & ~full_q;
  assign accept     = out_valid_q & bus.out_ready;
  assign other_full = full_q & ~(4'b0001 << sel_q);

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < 4; i++) begin
      a_d[i] = a_q[i];
      if (wr_en[i]) begin
        a_d[i]    = wdata[i];
        full_d[i] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (|full_q) begin
          sel_d       = rr_pick(full_q, ptr_q);
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          full_d[sel_q] = 1'b0;
          ptr_d         = sel_q + 2'd1;
          // Back-to-back grant only to slots already full; the drained slot
          // cannot refill in the same cycle.
          if (|other_full) begin
            sel_d = rr_pick(other_full, sel_q + 2'd1);
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      full_q      <= '0;
      sel_q       <= 2'd0;
      ptr_q       <= START_PTR;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) a_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) a_q[i] <= a_d[i];
    end
  end

  assign bus.in_ready  = ~full_q;
  assign bus.a0        = a_q[0];
  assign bus.a1        = a_q[1];
  assign bus.a2        = a_q[2];
  assign bus.a3        = a_q[3];
  assign bus.sel1      = sel_q[1];
  assign bus.sel2      = sel_q[0];
  assign bus.out_valid = out_valid_q;

`ifdef MUX_SEQ_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'(accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign deliv_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
